// File: rtl/uart_hex_tx_if.sv
// Handshake bundle between the key/switch front end and the hex UART transmitter.
interface uart_hex_tx_if;
   logic       send;
   logic [3:0] nibble;
   logic       ready;
   logic       overflow;
   logic       busy;
   logic       tx;

   modport master (output send, nibble, input ready, overflow, busy, tx);
   modport slave  (input send, nibble, output ready, overflow, busy, tx);
endinterface

// File: rtl/uart_hex_tx.sv
// UART 8N1 transmitter for hex nibbles: each accepted nibble is encoded to an
// uppercase ASCII character, queued in a small FIFO and shifted out LSB first.
module uart_hex_tx #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 9600,
   parameter int DIVISOR    = CLK_FREQ / BAUD,
   parameter int FIFO_DEPTH = 4
) (
   input logic         clk,
   input logic         rst,
   uart_hex_tx_if.slave bus
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   state_t        r_state;
   logic [7:0]    r_sh;
   logic [2:0]    r_bit_idx;
   logic [BW-1:0] r_baud;
   logic          r_tx;

   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_bit_end;
   logic [7:0]    w_ascii;

   // Fullness is judged on the registered count, so a pop in the same cycle
   // never rescues a send that arrives while the FIFO is full.
   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_push    = bus.send && !w_full;
   assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
   assign w_bit_end = (r_baud == BW'(DIVISOR - 1));

   // 'A'-10 == 8'h37, so letters are 8'h37 + nibble.
   assign w_ascii = (bus.nibble < 4'd10) ? (8'h30 + {4'h0, bus.nibble})
                                         : (8'h37 + {4'h0, bus.nibble});

   assign bus.ready    = !w_full;
   assign bus.overflow = r_overflow;
   assign bus.busy     = (r_state != S_IDLE) || (r_count != '0);
   assign bus.tx       = r_tx;

   // FIFO storage: written on every accepted send.
   // NOTE: the storage array has no reset; the pointers and count fully define
   // which entries are valid, so clearing the data would only cost logic.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_ascii;
   end

   // FIFO pointers, occupancy and the one-cycle overflow pulse.
   // NOTE: state registers use non-blocking assignments so every always_ff
   // sees the pre-edge values of the others regardless of evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= bus.send && w_full;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Frame FSM: start bit, eight data bits LSB first, stop bit; tx registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sh      <= '0;
         r_bit_idx <= '0;
         r_baud    <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_sh    <= r_mem[r_rd_ptr];
                  r_baud  <= '0;
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= r_sh[0];
                  r_state   <= S_DATA;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_sh      <= {1'b0, r_sh[7:1]};
                     r_tx      <= r_sh[1];
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule
